// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control bus: ID/EX/MEM status into the sequencer and the
// per-stage register enables back out to the datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instr;
  logic             id_valid;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_hold;
  logic             memwb_bubble;
  logic             mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: presents stage status, consumes enables.
  modport master (
    output id_instr, id_valid, ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold, memwb_bubble,
           mem_err, state, stall_cycles
  );

  // Sequencer side.
  modport slave (
    input  id_instr, id_valid, ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold, memwb_bubble,
           mem_err, state, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional macro HAZ_PERF_EN adds a saturating count of PC-stalled cycles;
// without it stall_cycles is tied to 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; load-use, redirect and memory waits detected
// MEM_WAIT | data memory busy; pipeline frozen, watchdog counting
// FLUSH    | drop the stale instruction fetched after a redirect
// ERR      | watchdog tripped; frozen until reset
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ERR      = 2'd3
  } state_e;

  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              pend_q, pend_d;
  logic              mem_err_q, mem_err_d;

  logic [4:0] rs1, rs2;
  logic       lu, mem_stall;
  logic       freeze, run_rules, flush_rules;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold, memwb_bubble;
  logic       unused_instr_bits;

  assign rs1       = bus.id_instr[19:15];
  assign rs2       = bus.id_instr[24:20];
  assign unused_instr_bits = ^{bus.id_instr[31:25], bus.id_instr[14:0]};
  assign lu        = bus.ex_memread & bus.id_valid & (bus.ex_rd != 5'd0) &
                     ((bus.ex_rd == rs1) | (bus.ex_rd == rs2));
  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  // Next-state and same-cycle (Mealy) stage enables.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pend_d       = pend_q;
    mem_err_d    = mem_err_q;
    freeze       = 1'b0;
    run_rules    = 1'b0;
    flush_rules  = 1'b0;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
          pend_d     = 1'b0;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.mem_ready) begin
          freeze = 1'b1;
          if (wait_cnt_q == WAIT_MAX) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else if (pend_q) begin
          // The redirect that preceded this wait still owes a stale-fetch drop.
          flush_rules = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
          pend_d     = 1'b1;
        end else begin
          flush_rules = 1'b1;
        end
      end
      default: begin
        freeze = 1'b1;
      end
    endcase

    if (freeze) begin
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end

    if (flush_rules) begin
      ifid_flush = 1'b1;
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      pend_d     = 1'b0;
      state_d    = RUN;
    end

    if (run_rules) begin
      if (bus.ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        state_d     = FLUSH;
      end else if (lu) begin
        idex_bubble = 1'b1;
        state_d     = RUN;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        state_d = RUN;
      end
    end

    if (!rst_n) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_hold   = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  // Sequencer state, watchdog count, pending-flush flag and sticky trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      pend_q     <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.ifid_we      = ifid_we;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_hold   = exmem_hold;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.mem_err      = mem_err_q;
  assign bus.state        = state_q;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  // Count cycles with the PC held, sticking at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_we && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl (TIMEOUT=4, small counter).
module tb_pipeline_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_hold;
    logic             memwb_bubble;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall;
  } exp_t;

  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  // stimulus for the current cycle
  logic        s_rst_n, s_valid, s_memread, s_br, s_req, s_rdy;
  logic [31:0] s_instr;
  logic [4:0]  s_rd;

  // reference model: what the pipeline is currently doing, in plain terms
  int m_frozen;      // frozen cycles so far in the current memory wait (0 = no wait)
  bit m_owe_drop;    // a redirect happened before the wait; stale fetch still to drop
  bit m_drop_next;   // previous cycle redirected; this cycle drops the stale fetch
  bit m_trapped;
  int m_stalls;

  localparam int A_FRZ = 0, A_DROP = 1, A_REDIR = 2, A_LU = 3, A_NORM = 4;

  function automatic int run_pick(input bit lu);
    if (s_br)    return A_REDIR;
    else if (lu) return A_LU;
    else         return A_NORM;
  endfunction

  task automatic model_step(output exp_t e);
    bit   lu;
    int   act;
    logic [4:0] rs1, rs2;
    e = '0;
    if (!s_rst_n) begin
      m_frozen = 0; m_owe_drop = 0; m_drop_next = 0; m_trapped = 0; m_stalls = 0;
      return;
    end
    rs1 = s_instr[19:15];
    rs2 = s_instr[24:20];
    lu  = s_memread && s_valid && (s_rd != 0) && (s_rd == rs1 || s_rd == rs2);
    e.mem_err = m_trapped;
    e.state   = m_trapped ? 2'd3 : (m_frozen > 0) ? 2'd1 : m_drop_next ? 2'd2 : 2'd0;
    e.stall   = CNT_W'(m_stalls);
    if (m_trapped) begin
      act = A_FRZ;
    end else if (m_frozen > 0) begin
      if (!s_rdy) begin
        act = A_FRZ;
        if (m_frozen + 1 == TIMEOUT + 1) begin
          m_trapped = 1; m_frozen = 0;
        end else begin
          m_frozen++;
        end
      end else begin
        m_frozen = 0;
        if (m_owe_drop) begin
          act = A_DROP; m_owe_drop = 0;
        end else begin
          act = run_pick(lu);
        end
      end
    end else if (m_drop_next) begin
      m_drop_next = 0;
      if (s_req && !s_rdy) begin
        act = A_FRZ; m_frozen = 1; m_owe_drop = 1;
      end else begin
        act = A_DROP;
      end
    end else if (s_req && !s_rdy) begin
      act = A_FRZ; m_frozen = 1; m_owe_drop = 0;
    end else begin
      act = run_pick(lu);
    end
    if (act == A_REDIR) m_drop_next = 1;
    e.pc_we        = (act == A_DROP) || (act == A_REDIR) || (act == A_NORM);
    e.ifid_we      = e.pc_we;
    e.ifid_flush   = (act == A_DROP) || (act == A_REDIR);
    e.idex_bubble  = (act == A_REDIR) || (act == A_LU);
    e.exmem_hold   = (act == A_FRZ);
    e.memwb_bubble = (act == A_FRZ);
`ifdef HAZ_PERF_EN
    if (!e.pc_we && m_stalls < CNT_MAX) m_stalls++;
`else
    e.stall = '0;
    m_stalls = 0;
`endif
  endtask

  // Apply the staged stimulus for one cycle and queue its expected response.
  task automatic issue();
    exp_t e;
    rst_n               = s_rst_n;
    bus.id_instr        = s_instr;
    bus.id_valid        = s_valid;
    bus.ex_memread      = s_memread;
    bus.ex_rd           = s_rd;
    bus.ex_branch_taken = s_br;
    bus.mem_req         = s_req;
    bus.mem_ready       = s_rdy;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_rst_n = 1; s_valid = 1; s_memread = 0; s_br = 0; s_req = 0; s_rdy = 0;
    s_instr = 32'h0000_0013; s_rd = 5'd0;
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] w;
    w = $urandom;
    w[19:15] = rs1;
    w[24:20] = rs2;
    return w;
  endfunction

  // Monitor: every cycle presents a full set of outputs; compare at the falling edge.
  initial begin
    exp_t e, a;
    int   cyc = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a.pc_we        = bus.pc_we;
        a.ifid_we      = bus.ifid_we;
        a.ifid_flush   = bus.ifid_flush;
        a.idex_bubble  = bus.idex_bubble;
        a.exmem_hold   = bus.exmem_hold;
        a.memwb_bubble = bus.memwb_bubble;
        a.mem_err      = bus.mem_err;
        a.state        = bus.state;
        a.stall        = bus.stall_cycles;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL ctl cyc=%0d {pc,ifid,flush,bub,hold,mwb,err,state,stall} act=%b exp=%b",
                   cyc, a, e);
        end
        cyc++;
      end
    end
  end

  initial begin
    int trap_len;
    int budget;
    m_frozen = 0; m_owe_drop = 0; m_drop_next = 0; m_trapped = 0; m_stalls = 0;
    idle();
    s_rst_n = 0; issue(); issue();
    idle(); issue();

    // load-use stall, then the bubble reaches EX
    s_memread = 1; s_rd = 5'd5; s_instr = mk_instr(5'd5, 5'd9); issue();
    idle(); issue();
    // rs2 match, and x0 never stalls
    s_memread = 1; s_rd = 5'd7; s_instr = mk_instr(5'd1, 5'd7); issue();
    s_memread = 1; s_rd = 5'd0; s_instr = mk_instr(5'd0, 5'd0); issue();
    s_valid = 0; s_memread = 1; s_rd = 5'd3; s_instr = mk_instr(5'd3, 5'd3); issue();
    idle(); issue();

    // taken branch: redirect, stale drop, back to run
    s_br = 1; issue(); idle(); issue(); issue();

    // memory wait of 3 frozen cycles, release, ready in the same cycle as req
    s_req = 1; s_rdy = 0; repeat (3) issue();
    s_rdy = 1; issue();
    idle(); s_req = 1; s_rdy = 1; issue();
    idle(); issue();

    // branch and wait together: freeze wins, branch re-seen on release
    s_br = 1; s_req = 1; s_rdy = 0; issue(); issue();
    s_rdy = 1; issue();
    idle(); issue(); issue();

    // flush then wait: drop owed until memory answers
    s_br = 1; issue();
    idle(); s_req = 1; s_rdy = 0; issue(); issue();
    s_rdy = 1; issue();
    idle(); issue();

    // watchdog, then long trap so the counter can saturate, then reset
    s_req = 1; s_rdy = 0; repeat (8) issue();
    s_rdy = 1; s_br = 1; repeat (70) issue();
    idle(); s_rst_n = 0; issue();
    idle(); issue(); issue();

    // randomized traffic
    trap_len = 0;
    for (int i = 0; i < 3000; i++) begin
      idle();
      s_rst_n   = ($urandom_range(0, 299) != 0);
      if (m_trapped) begin
        trap_len++;
        if (trap_len > int'($urandom_range(3, 20))) s_rst_n = 0;
      end
      if (!s_rst_n) trap_len = 0;
      s_valid   = ($urandom_range(0, 4) != 0);
      s_memread = $urandom_range(0, 1);
      s_rd      = 5'($urandom_range(0, 3));
      s_instr   = mk_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      s_br      = ($urandom_range(0, 6) == 0);
      s_req     = ($urandom_range(0, 3) == 0) || (m_frozen > 0);
      s_rdy     = (m_frozen > 0) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
      issue();
    end

    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It combines load-use detection (ID vs EX), taken-branch redirect, and multi-cycle data-memory waits into one prioritised set of pipeline-register enables. It sits beside the ID stage and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB control inputs. A watchdog traps a data memory that never answers.

## Interface
- TIMEOUT, 255: maximum data-memory wait length before trapping; must be 1 or more.
- CNT_W, 16: width of the stall performance counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_instr  in  32  instruction in ID; rs1 = [19:15], rs2 = [24:20].
- id_valid  in  1  ID holds a real instruction; 0 for a bubble.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_hold  out  1  hold ID/EX and EX/MEM contents.
- memwb_bubble  out  1  load NOP into MEM/WB.
- mem_err  out  1  sticky watchdog trap.
- state  out  2  FSM state: RUN=0, MEM_WAIT=1, FLUSH=2, ERR=3.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0.

## Operation
The FSM state is registered. All other outputs are combinational from the state and the current inputs (Mealy), so a stall takes effect in the same cycle it is detected.

- **Load-use condition (lu):**
  - ex_memread & id_valid & ex_rd!=0 & (ex_rd==rs1 | ex_rd==rs2).
- **Freeze output set:**
  - pc_we=0, ifid_we=0, exmem_hold=1, memwb_bubble=1.
  - ifid_flush=0, idex_bubble=0.
- **Normal output set:**
  - pc_we=1, ifid_we=1.
  - All other control outputs 0.
- **RUN state, first matching rule wins:**
  1. mem_req & !mem_ready: drive the freeze set. Next state MEM_WAIT, wait_cnt<=1, pend<=0.
  2. ex_branch_taken: drive ifid_flush=1, idex_bubble=1, pc_we=1, ifid_we=1. Next state FLUSH.
  3. lu: drive pc_we=0, ifid_we=0, idex_bubble=1. Stay in RUN.
  4. Otherwise: drive the normal set.
- **MEM_WAIT state:**
  - If !mem_ready: drive the freeze set.
    - If wait_cnt==TIMEOUT, next state ERR and mem_err<=1.
    - Otherwise wait_cnt<=wait_cnt+1.
  - If mem_ready: the freeze drops in this cycle.
    - If pend=1, behave as FLUSH (outputs and next state).
    - Otherwise apply RUN rules 2–4; the next state follows the rule applied (FLUSH or RUN).
- **FLUSH state:**
  - Purpose: the synchronous instruction memory delivers one stale instruction after a redirect.
  - Drive ifid_flush=1, pc_we=1, ifid_we=1. Next state RUN.
  - lu and ex_branch_taken are ignored in this state.
  - If mem_req & !mem_ready: drive the freeze set instead. Next state MEM_WAIT with pend<=1, wait_cnt<=1.
- **ERR state:**
  - Freeze set driven permanently; mem_err=1.
  - Exit only through rst_n.
- wait_cnt is $clog2(TIMEOUT+1) bits wide and never wraps.

## Timing
- While rst_n=0, internal state: state=RUN, wait_cnt=0, pend=0, mem_err=0, stall_cycles=0.
- While rst_n=0, all combinational control outputs are forced to 0.
- Reset asserted mid-wait or in ERR takes effect immediately (asynchronous). The first edge after release runs RUN rules.
- Stall and flush latency is 0 cycles, same-cycle combinational. State changes become visible after 1 edge.
- A load-use stall lasts exactly 1 cycle: the next cycle sees a bubble in EX, so ex_memread=0.
- mem_ready in the same cycle as mem_req: no freeze, 0 wait cycles.
- Branch taken and memory wait in the same RUN cycle: the memory freeze wins. EX is held, so the branch is re-seen on release.
- A freeze lasts at most TIMEOUT+1 cycles before ERR is entered.

## Configuration
- Macro: HAZ_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_we=0 while rst_n=1.
  - It saturates at 2^CNT_W-1.
- Undefined:
  - The counter logic is removed.
  - The stall_cycles port remains and is tied to 0.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_instr rs1=5, id_valid=1 -> pc_we=0, ifid_we=0, idex_bubble=1 for 1 cycle; state stays 0. The same with ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 in RUN -> ifid_flush=1 and idex_bubble=1 that cycle; next cycle state=2 with ifid_flush=1, idex_bubble=0; then state=0.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles -> freeze set for 3 cycles, state=1 from cycle 2; cycle 4 with mem_ready=1 -> pc_we=1, state returns to 0. stall_cycles=3 with HAZ_PERF_EN.
- Flush then wait: taken branch, then mem_req=1 with mem_ready=0 in FLUSH for 2 cycles -> freeze; on mem_ready, ifid_flush=1 (pend honoured); then state=0.
- Watchdog, TIMEOUT=4: mem_req=1, mem_ready=0 held -> 5 frozen cycles, then state=3 and mem_err=1 from cycle 6 onward. Later mem_ready=1 does not release; rst_n pulse low -> all outputs 0, state=0, mem_err=0.
